// File: rtl/ycbcr_frame_sched.sv
// ycbcr_frame_sched
//   Frame-level sequencer that sits in front of the rgb_to_ycbcr converter in
//   the OV5640 motion-detect path. Camera pixels are let into the converter
//   one whole frame at a time. Each frame is tagged as either a
//   background-refresh frame or a compare frame. The block tracks pixel
//   coordinates on the converter output and flags frame-size errors.
//
// Ports
//   clk, rst_n              pixel clock, asynchronous active-low reset
//   i_start                 start request, honoured only in IDLE
//   i_stop                  stop request; the current frame always completes
//   i_r/g/b_8b, i_h_sync,
//   i_v_sync, i_data_en     camera pixel bus (v_sync active high)
//   o_r/g/b_8b, o_h_sync,
//   o_v_sync, o_data_en     registered pixel bus to the converter; only
//                           data_en is gated by the RUN state
//   i_cvt_data_en           data_en returned by the converter
//   o_pix_x, o_pix_y        coordinates of the current converter output pixel
//   o_bg_frame              current frame is a background-refresh frame
//   o_frame_start           1-cycle pulse on entry to RUN
//   o_frame_done            1-cycle pulse once the last pixel left the converter
//   o_busy                  FSM is not in IDLE
//   o_size_err              sticky line/frame size mismatch
//   o_state                 FSM state, for debug and checkers
`timescale 1ns/1ps
module ycbcr_frame_sched #(
  parameter int H_ACT     = 640,
  parameter int V_ACT     = 480,
  parameter int BG_PERIOD = 16,
  parameter int PIPE_LAT  = 4,
  parameter int XW        = 11,
  parameter int YW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic [7:0]    i_r_8b,
  input  logic [7:0]    i_g_8b,
  input  logic [7:0]    i_b_8b,
  input  logic          i_h_sync,
  input  logic          i_v_sync,
  input  logic          i_data_en,
  output logic [7:0]    o_r_8b,
  output logic [7:0]    o_g_8b,
  output logic [7:0]    o_b_8b,
  output logic          o_h_sync,
  output logic          o_v_sync,
  output logic          o_data_en,
  input  logic          i_cvt_data_en,
  output logic [XW-1:0] o_pix_x,
  output logic [YW-1:0] o_pix_y,
  output logic          o_bg_frame,
  output logic          o_frame_start,
  output logic          o_frame_done,
  output logic          o_busy,
  output logic          o_size_err,
  output logic [1:0]    o_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_RUN     = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  localparam int FIW = (BG_PERIOD > 1) ? $clog2(BG_PERIOD) : 1;
  localparam int DW  = $clog2(PIPE_LAT + 2);

  localparam logic [XW-1:0]  X_ACT      = XW'(H_ACT);
  localparam logic [YW-1:0]  Y_ACT      = YW'(V_ACT);
  localparam logic [FIW-1:0] BG_LAST    = FIW'(BG_PERIOD - 1);
  localparam logic [DW-1:0]  DRAIN_LOAD = DW'(PIPE_LAT + 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_vs_d;
  logic           r_cde_d;
  logic           r_stop_pend;
  logic [DW-1:0]  r_drain_cnt;
  logic [FIW-1:0] r_frame_idx;
  logic [XW-1:0]  r_x_cnt;
  logic [YW-1:0]  r_y_cnt;

  logic           w_vs_rise;
  logic           w_vs_fall;
  logic           w_cde_fall;
  logic           w_drain_last;
  logic [XW-1:0]  w_x_inc;
  logic [YW-1:0]  w_y_inc;
  logic [YW-1:0]  w_y_nxt;

  assign w_vs_rise    = i_v_sync & ~r_vs_d;
  assign w_vs_fall    = ~i_v_sync & r_vs_d;
  assign w_cde_fall   = r_cde_d & ~i_cvt_data_en;
  // The drain counter is decremented every DRAIN cycle. The cycle in which
  // it reaches zero is the final one.
  assign w_drain_last = (r_drain_cnt <= DW'(1));

  // Both counters saturate at all-ones.
  assign w_x_inc = (&r_x_cnt) ? r_x_cnt : r_x_cnt + XW'(1);
  assign w_y_inc = (&r_y_cnt) ? r_y_cnt : r_y_cnt + YW'(1);
  // The last line's data_en may fall in the same cycle the drain ends.
  // The frame-size check therefore uses the line count including that fall.
  assign w_y_nxt = w_cde_fall ? w_y_inc : r_y_cnt;

  assign o_state = r_state;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_start && !i_stop) w_state_nxt = S_WAIT_VS;
      S_WAIT_VS: begin
        if (i_stop)         w_state_nxt = S_IDLE;
        else if (w_vs_fall) w_state_nxt = S_RUN;
      end
      S_RUN:     if (w_vs_rise) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (w_drain_last) w_state_nxt = (r_stop_pend || i_stop) ? S_IDLE : S_WAIT_VS;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_vs_d        <= 1'b0;
      r_cde_d       <= 1'b0;
      r_stop_pend   <= 1'b0;
      r_drain_cnt   <= '0;
      r_frame_idx   <= '0;
      r_x_cnt       <= '0;
      r_y_cnt       <= '0;
      o_r_8b        <= '0;
      o_g_8b        <= '0;
      o_b_8b        <= '0;
      o_h_sync      <= 1'b0;
      o_v_sync      <= 1'b0;
      o_data_en     <= 1'b0;
      o_pix_x       <= '0;
      o_pix_y       <= '0;
      o_bg_frame    <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_done  <= 1'b0;
      o_busy        <= 1'b0;
      o_size_err    <= 1'b0;
    end else begin
      o_r_8b        <= i_r_8b;
      o_g_8b        <= i_g_8b;
      o_b_8b        <= i_b_8b;
      o_h_sync      <= i_h_sync;
      o_v_sync      <= i_v_sync;
      o_data_en     <= i_data_en & (r_state == S_RUN);
      r_vs_d        <= i_v_sync;
      r_cde_d       <= i_cvt_data_en;
      r_state       <= w_state_nxt;
      o_busy        <= (w_state_nxt != S_IDLE);
      o_frame_start <= 1'b0;
      o_frame_done  <= 1'b0;

      // Coordinate tracking follows only the converter's data_en.
      if (i_cvt_data_en) begin
        o_pix_x <= r_x_cnt;
        o_pix_y <= r_y_cnt;
        r_x_cnt <= w_x_inc;
      end else if (w_cde_fall) begin
        if (r_x_cnt != X_ACT) o_size_err <= 1'b1;
        r_x_cnt <= '0;
        r_y_cnt <= w_y_inc;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start && !i_stop) begin
            r_frame_idx <= '0;
            o_size_err  <= 1'b0;
          end
        end
        S_WAIT_VS: begin
          if (w_state_nxt == S_RUN) begin
            o_frame_start <= 1'b1;
            o_bg_frame    <= (r_frame_idx == '0);
            r_x_cnt       <= '0;
            r_y_cnt       <= '0;
          end
        end
        S_RUN: begin
          if (i_stop)    r_stop_pend <= 1'b1;
          if (w_vs_rise) r_drain_cnt <= DRAIN_LOAD;
        end
        S_DRAIN: begin
          if (i_stop) r_stop_pend <= 1'b1;
          if (w_drain_last) begin
            r_drain_cnt  <= '0;
            o_frame_done <= 1'b1;
            if (w_y_nxt != Y_ACT) o_size_err <= 1'b1;
            r_frame_idx  <= (r_frame_idx == BG_LAST) ? '0 : r_frame_idx + FIW'(1);
          end else begin
            r_drain_cnt  <= r_drain_cnt - DW'(1);
          end
        end
        default: ;
      endcase

      // Any pending stop is consumed when the FSM returns to IDLE.
      if (w_state_nxt == S_IDLE) r_stop_pend <= 1'b0;
    end
  end

endmodule
